// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issue/response sequencer between the EXU and the iterative
// radix-4 Booth multiplier. It holds one RV64M multiply at a time, keeps the
// multiplier inputs frozen for the whole iteration, shapes the product into
// the rd value, and keeps a one-entry product cache so that a mulh*/mul pair
// on the same operands costs a single multiply.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a request (when the multiplier is also idle)
// RUN   | multiplier iterating on the accepted op, waiting for mul_out_valid
// DRAIN | op was flushed but is still inside the multiplier; result dropped
// RESP  | shaped result presented on the response channel
module mul_issue_ctrl #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic             req_word,
  input  logic [XLEN-1:0]  req_src1,
  input  logic [XLEN-1:0]  req_src2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             mul_valid,
  output logic             mul_word,
  output logic [1:0]       mul_signed,
  output logic [XLEN-1:0]  mul_a,
  output logic [XLEN-1:0]  mul_b,
  input  logic             mul_ready,
  input  logic             mul_out_valid,
  input  logic [XLEN-1:0]  mul_res_h,
  input  logic [XLEN-1:0]  mul_res_l
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;

  // accepted request, held stable while the multiplier iterates
  logic [1:0]       r_op;
  logic             r_word;
  logic [1:0]       r_sgn;
  logic [XLEN-1:0]  r_src1;
  logic [XLEN-1:0]  r_src2;
  logic [TAG_W-1:0] r_tag;

  logic [XLEN-1:0]  r_resp_data;
  logic [TAG_W-1:0] r_resp_tag;

  // one-entry product cache
  logic             r_c_valid;
  logic [XLEN-1:0]  r_c_src1;
  logic [XLEN-1:0]  r_c_src2;
  logic [1:0]       r_c_sgn;
  logic [XLEN-1:0]  r_c_res_h;
  logic [XLEN-1:0]  r_c_res_l;

  logic             w_accept;
  logic [1:0]       w_req_sgn;
  logic             w_hit;
  logic [XLEN-1:0]  w_hit_data;
  logic             w_done;
  logic             w_fill;
  logic             w_run_resp;
  logic [XLEN-1:0]  w_res_shaped;

  // Both hit and miss are gated by mul_ready so req_ready never depends on
  // the request payload.
  assign req_ready  = (r_state == ST_IDLE) && mul_ready;
  assign resp_valid = (r_state == ST_RESP);
  assign mul_valid  = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign mul_word   = r_word;
  assign mul_signed = r_sgn;
  assign mul_a      = r_src1;
  assign mul_b      = r_src2;
  assign resp_data  = r_resp_data;
  assign resp_tag   = r_resp_tag;

  assign w_accept = req_valid && req_ready && !flush;

  // Map the op encoding to {rs1_signed, rs2_signed}.
  always_comb begin
    w_req_sgn = 2'b11;
    case (req_op)
      OP_MUL:    w_req_sgn = 2'b11;
      OP_MULH:   w_req_sgn = 2'b11;
      OP_MULHSU: w_req_sgn = 2'b10;
      OP_MULHU:  w_req_sgn = 2'b00;
      default:   w_req_sgn = 2'b11;
    endcase
  end

  // The low half of a product does not depend on operand signedness, so a
  // plain mul may reuse an entry filled by any of the mulh variants.
  assign w_hit = r_c_valid && !req_word
                 && (req_src1 == r_c_src1) && (req_src2 == r_c_src2)
                 && ((req_op == OP_MUL) || (w_req_sgn == r_c_sgn));

  assign w_hit_data = (req_op == OP_MUL) ? r_c_res_l : r_c_res_h;

  // Any op leaving the multiplier, whether it will be answered or was flushed.
  assign w_done     = mul_out_valid && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
  assign w_fill     = w_done && !r_word;
  assign w_run_resp = (r_state == ST_RUN) && mul_out_valid && !flush;

  // Select the rd value from the 128-bit product.
  always_comb begin
    w_res_shaped = mul_res_h;
    if (r_word) begin
      w_res_shaped = {{(XLEN-32){mul_res_l[31]}}, mul_res_l[31:0]};
    end else if (r_op == OP_MUL) begin
      w_res_shaped = mul_res_l;
    end
  end

  // Next-state logic; completion beats flush only in the sense that a
  // flushed completion still returns straight to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_hit ? ST_RESP : ST_RUN;
        end
      end
      ST_RUN: begin
        if (mul_out_valid) begin
          w_state_nxt = flush ? ST_IDLE : ST_RESP;
        end else if (flush) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (mul_out_valid) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (flush || resp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the request at accept; these drive the multiplier directly.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_op   <= OP_MUL;
      r_word <= 1'b0;
      r_sgn  <= 2'b00;
      r_src1 <= '0;
      r_src2 <= '0;
      r_tag  <= '0;
    end else if (w_accept) begin
      r_op   <= req_op;
      r_word <= req_word;
      r_sgn  <= w_req_sgn;
      r_src1 <= req_src1;
      r_src2 <= req_src2;
      r_tag  <= req_tag;
    end
  end

  // Response register: loaded on a cache hit or a live completion, held
  // otherwise so backpressure sees stable data.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_resp_data <= '0;
      r_resp_tag  <= '0;
    end else if (w_accept && w_hit) begin
      r_resp_data <= w_hit_data;
      r_resp_tag  <= req_tag;
    end else if (w_run_resp) begin
      r_resp_data <= w_res_shaped;
      r_resp_tag  <= r_tag;
    end
  end

  // Product cache: refilled by every full-width completion, even a flushed
  // one, since the product itself is still correct for those operands.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_c_valid <= 1'b0;
      r_c_src1  <= '0;
      r_c_src2  <= '0;
      r_c_sgn   <= 2'b00;
      r_c_res_h <= '0;
      r_c_res_l <= '0;
    end else if (w_fill) begin
      r_c_valid <= 1'b1;
      r_c_src1  <= r_src1;
      r_c_src2  <= r_src2;
      r_c_sgn   <= r_sgn;
      r_c_res_h <= mul_res_h;
      r_c_res_l <= mul_res_l;
    end
  end

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
- Sequencing controller between the EXU and the radix-4 Booth iterative multiplier.
- Accepts one RV64M multiply request at a time (mul, mulh, mulhsu, mulhu, mulw) and holds operands and control stable for the whole iteration.
- Shapes the result (high/low select, mulw sign-extension) and returns it over a valid/ready response channel.
- Drains the multiplier cleanly on pipeline flush and keeps a one-entry product cache, so an adjacent mulh*/mul pair on the same operands costs one multiply.

Parameters:
- XLEN, 64, operand/result width; the multiplier datapath is fixed at 64.
- TAG_W, 5, width of the destination tag carried with each request.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  EXU presents a multiply
- req_ready  out  1  controller can accept
- req_op  in  2  00 mul, 01 mulh, 10 mulhsu, 11 mulhu
- req_word  in  1  mulw (only legal with req_op=00)
- req_src1  in  XLEN  rs1 value
- req_src2  in  XLEN  rs2 value
- req_tag  in  TAG_W  destination tag
- flush  in  1  kill in-flight/pending op
- resp_valid  out  1  result available
- resp_ready  in  1  EXU/WB consumes result
- resp_data  out  XLEN  final rd value
- resp_tag  out  TAG_W  tag of the result
- mul_valid  out  1  to multiplier MulValid
- mul_word  out  1  to multiplier Mulw
- mul_signed  out  2  {rs1_signed, rs2_signed}
- mul_a  out  XLEN  multiplicand = src1
- mul_b  out  XLEN  multiplier = src2
- mul_ready  in  1  multiplier idle
- mul_out_valid  in  1  multiplier result strobe
- mul_res_h  in  XLEN  product[127:64]
- mul_res_l  in  XLEN  product[63:0]

Behaviour:
- Reset values:
  - State IDLE; req_ready=1; resp_valid=0; mul_valid=0.
  - resp_data, resp_tag, mul_a, mul_b, mul_word, mul_signed all 0.
  - Cache invalid.
- States:
  - IDLE: req_ready=1.
  - RUN: mul_valid=1, waiting for mul_out_valid.
  - DRAIN: killed op still in multiplier; mul_valid=1, result discarded.
  - RESP: resp_valid=1, waiting for resp_ready.
- Accept: req_valid & req_ready & ~flush. Latch op, word, src1, src2 and tag into registers.
- Signedness mapping: mul/mulh/mulw -> 2'b11; mulhsu -> 2'b10; mulhu -> 2'b00.
- Cache hit (checked at accept) requires all of:
  - cache valid, ~req_word, src1 and src2 equal to the cached values;
  - and either req_op=mul, or the requested signedness equals the cached signedness.
- On a hit: go IDLE -> RESP; resp_valid rises 1 cycle after accept; multiplier untouched.
- On a miss: go IDLE -> RUN. This requires mul_ready=1; while mul_ready=0, req_ready=0.
- Multiplier hold rules (it advances only while MulValid=1 and samples operands every cycle):
  - mul_valid stays 1 from the cycle after accept through the cycle mul_out_valid=1 inclusive, then drops.
  - mul_a, mul_b, mul_word and mul_signed come from registers and are constant for the whole op.
- Latency: nominal 34 cycles accept->resp_valid for 64-bit ops, 18 for mulw. The controller relies only on mul_out_valid, never on a cycle count.
- RUN with mul_out_valid=1 -> RESP. resp_data is registered that cycle:
  - mul: res_l.
  - mulh/mulhsu/mulhu: res_h.
  - mulw: sign-extended res_l[31:0].
- Cache fill: on every non-word completion, including in DRAIN, store {src1, src2, signedness, res_h, res_l}. Word completions leave the cache unchanged.
- RESP & resp_ready -> IDLE. resp_data and resp_tag stay stable while resp_valid=1 & ~resp_ready.
- Flush handling:
  - RUN & flush -> DRAIN.
  - DRAIN & mul_out_valid -> IDLE with no response.
  - RESP & flush -> IDLE; the response is dropped and resp_valid falls next cycle.
  - IDLE & flush: the request is not accepted.
  - Flush in the same cycle as mul_out_valid in RUN -> IDLE, no response.
- Reset mid-operation returns to IDLE with mul_valid=0. The multiplier shares the same reset, so both sides resynchronise.
- req_ready=0 in RUN, DRAIN and RESP; there is no request queueing.

Test Plan:
- Basic mul: mul 3×5, tag 7 -> resp_data=15, resp_tag=7; mul_valid high continuously for 33 cycles; mul_a/mul_b constant throughout.
- mulh/mulhu: mulh 0xFFFF_FFFF_FFFF_FFFF×0xFFFF_FFFF_FFFF_FFFF -> 0. mulhu on the same operands (signedness differs, so a miss) -> 0xFFFF_FFFF_FFFF_FFFE with mul_signed=00.
- mulw: 0x7FFF_FFFF×2 -> 0xFFFF_FFFF_FFFF_FFFE, 18-cycle latency, mul_word=1 held. A following mul on the same operands is a cache miss.
- Cache hit: mulhu 0xFFFF_FFFF_FFFF_FFFF×0xFFFF_FFFF_FFFF_FFFF, then mul with the same operands -> resp_valid 1 cycle after accept, data 0x0000_0000_0000_0001, mul_valid never asserted.
- Flush mid-run: flush at cycle 10 of a mul -> no resp_valid, req_ready=0 until mul_out_valid, then 1. The next mul 2×2 returns 4.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid, resp_data and resp_tag stable. A flush during RESP drops the response; reset mid-RUN -> IDLE, mul_valid=0 next cycle.
